// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package irq_ctrl_pkg;

  // Byte offsets inside the 256-byte register window
  localparam logic [7:0] REG_ENABLE  = 8'h00;
  localparam logic [7:0] REG_PENDING = 8'h04;
  localparam logic [7:0] REG_MODE    = 8'h08;
  localparam logic [7:0] REG_POL     = 8'h0C;
  localparam logic [7:0] REG_RAW     = 8'h10;
  localparam logic [7:0] REG_ID      = 8'h14;

  // Per-channel trigger mode encoding
  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  // Expand byte strobes into a 32-bit bit mask
  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

  // Replace only the strobed bytes of a register value
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] wdata,
                                               input logic [31:0] mask);
    return (old_val & ~mask) | (wdata & mask);
  endfunction

endpackage

// File: rtl/irq_chan.sv
// One interrupt channel: 2-flop sync, polarity, edge detect, pending bit.
// Latency: pin sampled at edge k -> raw at k+1 -> pending at k+2.
// Backpressure: none; clr is a single-cycle W1C strobe, a coincident set wins.
module irq_chan
  import irq_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  input  logic enable,
  input  logic mode,
  input  logic pol,
  input  logic clr,
  output logic pending,
  output logic raw,
  output logic active
);

  logic s1;
  logic s2;
  logic qd;
  logic q;

  // q uses the current polarity, so a POL flip is seen as a real (latched) edge
  assign q      = s2 ^ pol;
  assign raw    = s2;
  assign active = pending & enable;

  // Synchroniser and edge history; qd tracks q in every mode so a mode change is never an edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      qd <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
      qd <= q;
    end
  end

  // Pending bit: follows the level, or latches edges until cleared by software
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending <= 1'b0;
    end else begin
      unique case (mode)
        MODE_LEVEL: pending <= q;
        MODE_EDGE: begin
          if (q && !qd)  pending <= 1'b1;
          else if (clr)  pending <= 1'b0;
        end
        default: pending <= pending;
      endcase
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// picoRV32 interrupt controller: N_IRQ lines, bus-mapped registers, irq vector.
// Latency: pin to cpu_irq 3 clocks after sampling; bus access acked 1 clock after request.
// Backpressure: one mem_ready pulse per access, then one idle cycle before the next.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int          N_IRQ     = 3,
  parameter int          IRQ_BASE  = 5,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic             mem_ready,
  output logic [31:0]      mem_rdata,
  output logic [31:0]      cpu_irq
);

  localparam logic [31:0] IMPL_MASK = 32'((64'd1 << N_IRQ) - 64'd1);

  logic [31:0]      enable_q;
  logic [31:0]      mode_q;
  logic [31:0]      pol_q;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] raw;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] clr;
  logic             bus_armed;
  logic             acc;
  logic             wr;
  logic [31:0]      bmask;
  logic [31:0]      rd_val;
  logic [31:0]      id_val;

  // An access is taken only when not already acknowledging; bus_armed blocks a
  // request that was held across reset until the CPU re-presents it.
  assign acc   = mem_valid && (mem_addr[31:8] == BASE_ADDR[31:8]) && bus_armed && !mem_ready;
  assign wr    = acc && (mem_wstrb != 4'b0000);
  assign bmask = strb_mask(mem_wstrb);
  assign clr   = (wr && (mem_addr[7:0] == REG_PENDING)) ?
                 (mem_wdata[N_IRQ-1:0] & bmask[N_IRQ-1:0]) : '0;

  for (genvar i = 0; i < N_IRQ; i++) begin : g_chan
    irq_chan u_chan (
      .clk     (clk),
      .reset   (reset),
      .irq_in  (irq_in[i]),
      .enable  (enable_q[i]),
      .mode    (mode_q[i]),
      .pol     (pol_q[i]),
      .clr     (clr[i]),
      .pending (pending[i]),
      .raw     (raw[i]),
      .active  (active[i])
    );
  end

  // Lowest-index enabled pending channel wins
  always_comb begin
    id_val = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (active[i]) id_val = {1'b1, 26'd0, 5'(i)};
    end
  end

  // Read mux; unmapped offsets return 0
  always_comb begin
    rd_val = '0;
    case (mem_addr[7:0])
      REG_ENABLE:  rd_val = enable_q;
      REG_PENDING: rd_val = 32'(pending);
      REG_MODE:    rd_val = mode_q;
      REG_POL:     rd_val = pol_q;
      REG_RAW:     rd_val = 32'(raw);
      REG_ID:      rd_val = id_val;
      default:     rd_val = '0;
    endcase
  end

  // Handshake and read data; rdata is forced to 0 outside the ready cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      bus_armed <= 1'b0;
    end else begin
      mem_ready <= acc;
      mem_rdata <= acc ? rd_val : '0;
      bus_armed <= bus_armed || !mem_valid;
    end
  end

  // Configuration registers; writes commit on the edge that raises mem_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_q <= '0;
      mode_q   <= '0;
      pol_q    <= '0;
    end else if (wr) begin
      case (mem_addr[7:0])
        REG_ENABLE: enable_q <= merge_bytes(enable_q, mem_wdata, bmask) & IMPL_MASK;
        REG_MODE:   mode_q   <= merge_bytes(mode_q, mem_wdata, bmask) & IMPL_MASK;
        REG_POL:    pol_q    <= merge_bytes(pol_q, mem_wdata, bmask) & IMPL_MASK;
        default: ;
      endcase
    end
  end

  // Registered irq vector to the CPU
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cpu_irq <= '0;
    else       cpu_irq <= 32'(active) << IRQ_BASE;
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus random traffic.
// Latency: outputs compared every falling edge against a cycle model.
// Backpressure: bus driver waits for mem_ready with a bounded budget.
module tb_irq_ctrl;

  localparam int          TB_N     = 3;
  localparam int          IRQ_BASE = 5;
  localparam logic [31:0] BASE     = 32'h0300_0000;

  logic            clk = 1'b0;
  logic            reset;
  logic [TB_N-1:0] irq_in;
  logic            mem_valid;
  logic [31:0]     mem_addr;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_wstrb;
  logic            mem_ready;
  logic [31:0]     mem_rdata;
  logic [31:0]     cpu_irq;

  int n_checks = 0;
  int n_fail   = 0;

  irq_ctrl #(.N_IRQ(TB_N), .IRQ_BASE(IRQ_BASE), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_in    (irq_in),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .cpu_irq   (cpu_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [TB_N-1:0] m_en, m_mode, m_pol, m_pend, m_qprev;
  logic [31:0]     m_cpu, m_rdata;
  logic            m_ready, m_armed;
  logic [TB_N-1:0] hist[$];

  function automatic logic [31:0] id_of(input logic [TB_N-1:0] a);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < TB_N; i++)
      if (a[i] && r == 0) r = 32'h8000_0000 | 32'(i);
    return r;
  endfunction

  task model_step();
    logic [TB_N-1:0] sync, q, edg, clr, act;
    logic [31:0]     rdv;
    logic            acc;
    if (reset) begin
      m_en = '0; m_mode = '0; m_pol = '0; m_pend = '0; m_qprev = '0;
      m_cpu = '0; m_rdata = '0; m_ready = 1'b0; m_armed = 1'b0;
      hist.delete();
    end else begin
      // pins reach the synchronised view two sampling edges later
      sync = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      q    = sync ^ m_pol;
      edg  = q & ~m_qprev;
      act  = m_pend & m_en;
      acc  = mem_valid && (mem_addr[31:8] == BASE[31:8]) && m_armed && !m_ready;
      rdv  = '0;
      clr  = '0;
      if (acc) begin
        case (mem_addr[7:0])
          8'h00: rdv = 32'(m_en);
          8'h04: rdv = 32'(m_pend);
          8'h08: rdv = 32'(m_mode);
          8'h0C: rdv = 32'(m_pol);
          8'h10: rdv = 32'(sync);
          8'h14: rdv = id_of(act);
          default: rdv = '0;
        endcase
        if (mem_wstrb[0] && mem_addr[7:0] == 8'h04) clr = mem_wdata[TB_N-1:0];
      end
      m_pend  = (~m_mode & q) | (m_mode & ((m_pend & ~clr) | edg));
      m_qprev = q;
      m_cpu   = 32'(act) << IRQ_BASE;
      if (acc && mem_wstrb[0]) begin
        case (mem_addr[7:0])
          8'h00: m_en   = mem_wdata[TB_N-1:0];
          8'h08: m_mode = mem_wdata[TB_N-1:0];
          8'h0C: m_pol  = mem_wdata[TB_N-1:0];
          default: ;
        endcase
      end
      m_ready = acc;
      m_rdata = rdv;
      m_armed = m_armed || !mem_valid;
      hist.push_back(irq_in);
      if (hist.size() > 2) void'(hist.pop_front());
    end
  endtask

  always @(posedge clk or posedge reset) model_step();

  // Continuous comparison against the model
  always @(negedge clk) begin
    if (!reset) begin
      check("cpu_irq", cpu_irq, m_cpu);
      check("mem_ready", 32'(mem_ready), 32'(m_ready));
      check("mem_rdata", mem_rdata, m_rdata);
    end
  end

  // ---------------- bus driver ----------------
  task automatic bus_xfer(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, output logic [31:0] rdata);
    int n;
    mem_valid = 1'b1; mem_addr = addr; mem_wdata = wdata; mem_wstrb = wstrb;
    n = 0;
    rdata = '0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready && n < 8);
    if (!mem_ready) check("bus_timeout", 32'(mem_ready), 32'd1);
    else            rdata = mem_rdata;
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [7:0] off, input logic [31:0] d);
    logic [31:0] dummy;
    bus_xfer(BASE + 32'(off), d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [7:0] off, output logic [31:0] d);
    bus_xfer(BASE + 32'(off), 32'h0, 4'h0, d);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] r;
    int          cnt;
    logic [7:0]  off;

    reset = 1'b1; irq_in = '0; mem_valid = 1'b0;
    mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    @(negedge clk);
    check("rst0_cpu", cpu_irq, 32'h0);
    check("rst0_ready", 32'(mem_ready), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Edge latch and clear
    wr(8'h08, 32'h7);
    wr(8'h00, 32'h7);
    irq_in = 3'b001;
    repeat (3) @(negedge clk);
    check("edge_pre", cpu_irq, 32'h0);
    @(negedge clk);
    check("edge_lat", cpu_irq, 32'h20);
    repeat (16) @(negedge clk);
    irq_in = 3'b000;
    repeat (6) @(negedge clk);
    check("edge_hold", cpu_irq, 32'h20);
    wr(8'h04, 32'h1);
    @(negedge clk);
    check("w1c", cpu_irq, 32'h0);

    // Level mode and polarity
    wr(8'h08, 32'h0);
    wr(8'h0C, 32'h4);
    wr(8'h00, 32'h4);
    repeat (4) @(negedge clk);
    check("lvl_pol", cpu_irq, 32'h80);
    irq_in = 3'b100;
    repeat (3) @(negedge clk);
    check("lvl_hold", cpu_irq, 32'h80);
    @(negedge clk);
    check("lvl_drop", cpu_irq, 32'h0);
    irq_in = 3'b000;
    repeat (4) @(negedge clk);
    wr(8'h04, 32'h4);
    @(negedge clk);
    check("lvl_w1c", cpu_irq, 32'h80);

    // Simultaneous set and clear on channel 1
    wr(8'h08, 32'h7);
    irq_in = 3'b010;
    repeat (2) @(negedge clk);
    wr(8'h04, 32'h2);
    rd(8'h04, r);
    check("pend_sc", r, 32'h6);

    // Priority ID and re-enable latency
    wr(8'h00, 32'h4);
    rd(8'h14, r);
    check("id_ch2", r, 32'h8000_0002);
    wr(8'h00, 32'h6);
    @(negedge clk);
    check("reenable", cpu_irq, 32'hC0);
    rd(8'h14, r);
    check("id_ch1", r, 32'h8000_0001);

    // Held request: one ready pulse per access
    mem_valid = 1'b1; mem_addr = BASE + 32'h8; mem_wstrb = 4'h0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(mem_ready);
    end
    mem_valid = 1'b0;
    check("hold_ready_cnt", 32'(cnt), 32'd2);
    @(negedge clk);

    // Outside the window
    mem_valid = 1'b1; mem_addr = BASE + 32'h100; mem_wdata = '1; mem_wstrb = 4'hF;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      cnt += int'(mem_ready);
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    check("oow_ready", 32'(cnt), 32'd0);
    rd(8'h00, r);
    check("oow_nochange", r, 32'h6);

    // Unimplemented bits
    wr(8'h00, 32'h8000_0007);
    rd(8'h00, r);
    check("unimpl_bit", r, 32'h7);

    // Reset in the middle of a write
    irq_in = 3'b000;
    repeat (4) @(negedge clk);
    mem_valid = 1'b1; mem_addr = BASE; mem_wdata = 32'h5; mem_wstrb = 4'hF;
    #2 reset = 1'b1;
    #1;
    check("rst_cpu", cpu_irq, 32'h0);
    check("rst_ready", 32'(mem_ready), 32'h0);
    check("rst_rdata", mem_rdata, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      cnt += int'(mem_ready);
    end
    check("rst_noack", 32'(cnt), 32'd0);
    mem_valid = 1'b0; mem_wstrb = 4'h0;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      rd(8'(k * 4), r);
      check("rst_reg", r, 32'h0);
    end

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) irq_in = TB_N'($urandom);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      if (!mem_valid || mem_ready || $urandom_range(0, 5) == 0) begin
        mem_valid = ($urandom_range(0, 2) != 0);
        off       = 8'($urandom_range(0, 7) * 4);
        mem_addr  = ($urandom_range(0, 9) == 0) ? BASE + 32'h100 + 32'(off) : BASE + 32'(off);
        mem_wdata = $urandom;
        case ($urandom_range(0, 3))
          0:       mem_wstrb = 4'h0;
          1:       mem_wstrb = 4'hF;
          2:       mem_wstrb = 4'h1;
          default: mem_wstrb = 4'($urandom);
        endcase
      end
    end
    mem_valid = 1'b0; mem_wstrb = 4'h0; reset = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Parametrised interrupt controller for the picoRV32 SoC.
- Replaces the fixed irq_5/irq_6/irq_7 pin wiring with N_IRQ external lines.
- Each line has an enable bit, an edge/level mode bit and a polarity bit.
- Pending state is latched and cleared by software over the native picoRV32 memory bus.
- Drives the CPU's 32-bit irq vector starting at bit IRQ_BASE.

Parameters:
N_IRQ, 3, number of external interrupt lines (1..24).
IRQ_BASE, 5, CPU irq bit driven by channel 0; requires IRQ_BASE+N_IRQ <= 32.
BASE_ADDR, 32'h0300_0000, register window base; the window is 256 bytes, decoded on addr[31:8].

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
irq_in  input  N_IRQ  raw external interrupt pins, asynchronous to clk
mem_valid  input  1  picoRV32 bus request
mem_addr  input  32  byte address
mem_wdata  input  32  write data
mem_wstrb  input  4  byte write strobes; 0 means read
mem_ready  output  1  single-cycle access acknowledge
mem_rdata  output  32  read data, valid while mem_ready=1, else 0
cpu_irq  output  32  irq vector to the CPU

Behaviour:
- Reset is asynchronous and active-high. While reset=1, all of the following are 0:
  - outputs mem_ready, mem_rdata, cpu_irq;
  - registers ENABLE, PENDING, MODE, POL;
  - synchroniser and edge-history flops.
- Synchronisation: each irq_in bit passes through 2 flops (s1, s2). q = s2 XOR POL[i]; qd = q delayed by one clock.
- Edge mode (MODE[i]=1):
  - PENDING[i] sets on the cycle where q=1 and qd=0.
  - PENDING[i] clears on a W1C write to PENDING.
  - If a set and a clear occur in the same cycle, set wins.
- Level mode (MODE[i]=0):
  - PENDING[i] <= q every cycle; W1C has no effect.
- Changing MODE or POL does not create a spurious edge:
  - qd is updated from the new q in the same cycle;
  - a POL flip may produce one legitimate edge, which is latched.
- Output: cpu_irq[IRQ_BASE+i] <= PENDING[i] & ENABLE[i] (registered). All other cpu_irq bits are 0.
- Latency: an input change sampled at clock edge k appears at s2 at k+1, in PENDING at k+2, and on cpu_irq at k+3.
- Bus decode: sel = mem_valid & (mem_addr[31:8] == BASE_ADDR[31:8]).
- Bus handshake:
  - mem_ready <= sel & ~mem_ready, giving exactly one ready pulse per access.
  - Wait state = 1 cycle; back-to-back accesses are separated by one idle cycle.
  - A write commits on the same clock edge that raises mem_ready.
  - Only mem_wstrb bytes covering bits < N_IRQ matter; unimplemented bits read 0.
- Register map (offset):
  - 0x00 ENABLE: RW.
  - 0x04 PENDING: read; write-1-to-clear.
  - 0x08 MODE: RW, 1 = edge.
  - 0x0C POL: RW, 1 = active-low / falling edge.
  - 0x10 RAW: RO, s2 value.
  - 0x14 ID: RO; bit31 = any (PENDING & ENABLE); bits[4:0] = lowest-index enabled pending channel.
- Unmapped offsets inside the window read 0; writes to them are ignored.
- Addresses outside the window: no mem_ready and no state change.
- Reset asserted mid-access: mem_ready drops immediately and the write is lost. After reset release, the CPU access is not acknowledged until mem_valid is re-presented.
- Disabling a channel (ENABLE=0) leaves PENDING latched; re-enabling raises cpu_irq 1 cycle after the write.

Decomposition:
- Package irq_ctrl_pkg holds:
  - register offset constants REG_ENABLE..REG_ID;
  - localparams MODE_LEVEL=0 and MODE_EDGE=1.
- One natural sub-module: irq_chan, per channel, generated N_IRQ times. It contains the 2-flop sync, the polarity XOR, the edge detector and the PENDING bit. Its inputs are enable, mode, pol and clr; its outputs are pending and raw.
- The top level holds the bus decode, the registers, the priority encoder for ID, and the cpu_irq output register.

Test Plan:
- Reset values: assert reset mid-run at an arbitrary time -> all outputs 0 asynchronously; after release, reading 0x00..0x14 returns 0.
- Edge latch and clear:
  - Setup: MODE=0x7, ENABLE=0x7, then a 20-cycle pulse on irq_in[0].
  - Expect cpu_irq = 32'h20 exactly 3 clocks after the sampled rise, and it stays after the pulse ends.
  - Write 0x1 to 0x04 -> cpu_irq=0 two clocks later.
- Level mode and polarity:
  - Setup: MODE=0, POL=0x4, ENABLE=0x4, irq_in[2]=0.
  - Expect cpu_irq[7]=1; driving irq_in[2]=1 gives cpu_irq[7]=0 three clocks later.
  - W1C on PENDING has no effect while the level is active.
- Simultaneous set and clear: in edge mode, align the W1C commit edge with the edge-detect cycle of channel 1 -> PENDING[1] remains 1.
- Priority ID: pend channels 2 and 1, with only channel 2 enabled -> ID reads 32'h8000_0002; enable channel 1 -> ID reads 32'h8000_0001.
- Bus handshake:
  - Hold mem_valid for 4 cycles to 0x08 -> mem_ready high for exactly 1 cycle per access.
  - Access to BASE_ADDR+0x100 -> mem_ready never asserts.
  - Unimplemented bit 31 written to ENABLE reads back 0.
